// File: rtl/wave_pkg.sv
// Shared definitions for the wave_sequencer step sequencer.
// Holds generator waveform codes, default parameter values,
// table-entry field geometry and the sequencer state encoding.
package wave_pkg;

  // Waveform select codes understood by the tone generator
  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  // Default sizing
  localparam int unsigned DEF_STEPS  = 8;
  localparam int unsigned DEF_DUR_W  = 8;
  localparam int unsigned DEF_FREQ_W = 6;
  localparam int unsigned DEF_PRESC  = 1000;

  // Table entry layout, LSB first: {wave, freq, dur}
  localparam int unsigned WAVE_W = 2;

  function automatic int unsigned entry_w(input int unsigned freq_w, input int unsigned dur_w);
    return WAVE_W + freq_w + dur_w;
  endfunction

  function automatic int unsigned freq_lsb(input int unsigned dur_w);
    return dur_w;
  endfunction

  function automatic int unsigned wave_lsb(input int unsigned freq_w, input int unsigned dur_w);
    return dur_w + freq_w;
  endfunction

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/wave_tick_prescaler.sv
// Duration tick prescaler: divides clk down to one tick every PRESC cycles.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clr_i       synchronous clear of the count (wins over en_i)
//   en_i        advance the count this cycle
//   tick_c_o    combinational: count is on its last value (PRESC-1)
module wave_tick_prescaler
  import wave_pkg::*;
#(
  parameter int unsigned PRESC = DEF_PRESC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = $clog2(PRESC) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c_o = (cnt_q == CNT_W'(PRESC - 1));

  // Compare precedes increment, so the count wraps at PRESC-1 and never overflows
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_c_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// Programmable step sequencer driving the tt_um_waves tone generator.
// A table of {wave, freq, dur} steps is played in order; each step holds its
// generator config for dur*PRESC cycles. dur==0 or running off the table end
// terminates (or wraps to entry 0 when loop_en is set).
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   ena                        global enable; low freezes everything
//   wr_en, wr_addr, wr_data    table write port (accepted in IDLE only)
//   start, stop, loop_en       sequence control
//   wave_sel, freq_code        generator config of the playing step
//   gen_en, busy               high while a step is playing
//   step_idx                   index of the playing step
//   done                       one-cycle end-of-sequence pulse
module wave_sequencer
  import wave_pkg::*;
#(
  parameter int unsigned STEPS  = DEF_STEPS,
  parameter int unsigned DUR_W  = DEF_DUR_W,
  parameter int unsigned FREQ_W = DEF_FREQ_W,
  parameter int unsigned PRESC  = DEF_PRESC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        wr_en,
  input  logic [$clog2(STEPS)-1:0]    wr_addr,
  input  logic [2+FREQ_W+DUR_W-1:0]   wr_data,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop_en,
  output logic [1:0]                  wave_sel,
  output logic [FREQ_W-1:0]           freq_code,
  output logic                        gen_en,
  output logic [$clog2(STEPS)-1:0]    step_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned IDX_W    = $clog2(STEPS);
  localparam int unsigned ENT_W    = entry_w(FREQ_W, DUR_W);
  localparam int unsigned FREQ_LSB = freq_lsb(DUR_W);
  localparam int unsigned WAVE_LSB = wave_lsb(FREQ_W, DUR_W);

  function automatic logic [DUR_W-1:0] f_dur(input logic [ENT_W-1:0] e);
    return e[DUR_W-1:0];
  endfunction

  function automatic logic [FREQ_W-1:0] f_freq(input logic [ENT_W-1:0] e);
    return e[FREQ_LSB +: FREQ_W];
  endfunction

  function automatic logic [1:0] f_wave(input logic [ENT_W-1:0] e);
    return e[WAVE_LSB +: WAVE_W];
  endfunction

  logic [ENT_W-1:0]  tbl_q [STEPS];

  logic [1:0]        state_q,   state_d;
  logic [1:0]        wave_q,    wave_d;
  logic [FREQ_W-1:0] freq_q,    freq_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [DUR_W-1:0]  dur_q,     dur_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic              gen_en_q,  gen_en_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic              presc_tick_c;
  logic              last_c;
  logic              load_c;
  logic              finish_c;
  logic [IDX_W-1:0]  load_idx_c;
  logic [ENT_W-1:0]  load_ent_c;
  logic [IDX_W:0]    nxt_c;
  logic [ENT_W-1:0]  nxt_ent_c;

  // Prescaler only runs while playing; it self-wraps at a step boundary
  wave_tick_prescaler #(
    .PRESC (PRESC)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (ena && (state_q != ST_RUN)),
    .en_i     (ena && (state_q == ST_RUN)),
    .tick_c_o (presc_tick_c)
  );

  // Step table; writes only land while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STEPS); i++) begin
        tbl_q[i] <= '0;
      end
    end else if (ena && wr_en && (state_q == ST_IDLE)) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    wave_d     = wave_q;
    freq_d     = freq_q;
    idx_d      = idx_q;
    dur_d      = dur_q;
    dur_cnt_d  = dur_cnt_q;
    gen_en_d   = gen_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_c     = 1'b0;
    finish_c   = 1'b0;
    load_idx_c = '0;

    // Overflow bit of nxt_c marks running past the last entry
    nxt_c     = {1'b0, idx_q} + (IDX_W+1)'(1);
    nxt_ent_c = tbl_q[nxt_c[IDX_W-1:0]];
    last_c    = presc_tick_c && (dur_cnt_q == dur_q - DUR_W'(1));

    case (state_q)
      ST_IDLE: begin
        gen_en_d = 1'b0;
        busy_d   = 1'b0;
        if (start && !stop) begin
          if (f_dur(tbl_q[0]) != '0) begin
            load_c = 1'b1;
          end else begin
            finish_c = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          finish_c = 1'b1;
        end else if (last_c) begin
          if (!nxt_c[IDX_W] && (f_dur(nxt_ent_c) != '0)) begin
            load_c     = 1'b1;
            load_idx_c = nxt_c[IDX_W-1:0];
          end else if (loop_en && (f_dur(tbl_q[0]) != '0)) begin
            load_c = 1'b1;
          end else begin
            finish_c = 1'b1;
          end
        end else if (presc_tick_c) begin
          dur_cnt_d = dur_cnt_q + DUR_W'(1);
        end
      end
      ST_FINISH: begin
        state_d   = ST_IDLE;
        dur_cnt_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    load_ent_c = tbl_q[load_idx_c];

    if (load_c) begin
      state_d   = ST_RUN;
      wave_d    = f_wave(load_ent_c);
      freq_d    = f_freq(load_ent_c);
      idx_d     = load_idx_c;
      dur_d     = f_dur(load_ent_c);
      dur_cnt_d = '0;
      gen_en_d  = 1'b1;
      busy_d    = 1'b1;
    end

    // wave/freq/idx keep the last step's values through FINISH
    if (finish_c) begin
      state_d  = ST_FINISH;
      done_d   = 1'b1;
      gen_en_d = 1'b0;
      busy_d   = 1'b0;
    end
  end

  // State register; ena low holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wave_q    <= '0;
      freq_q    <= '0;
      idx_q     <= '0;
      dur_q     <= '0;
      dur_cnt_q <= '0;
      gen_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      wave_q    <= wave_d;
      freq_q    <= freq_d;
      idx_q     <= idx_d;
      dur_q     <= dur_d;
      dur_cnt_q <= dur_cnt_d;
      gen_en_q  <= gen_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wave_sel  = wave_q;
  assign freq_code = freq_q;
  assign gen_en    = gen_en_q;
  assign step_idx  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Bench for wave_sequencer (PRESC=4). A step-level model counts each step
// down in whole cycles (dur*PRESC) and predicts outputs every cycle; directed
// scenarios add hand-computed literal checks.
module tb_wave_sequencer;
  import wave_pkg::*;

  localparam int PRESC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [1:0]  wave_sel;
  logic [5:0]  freq_code;
  logic        gen_en;
  logic [2:0]  step_idx;
  logic        busy;
  logic        done;

  wave_sequencer #(
    .STEPS  (8),
    .DUR_W  (8),
    .FREQ_W (6),
    .PRESC  (PRESC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .wave_sel  (wave_sel),
    .freq_code (freq_code),
    .gen_en    (gen_en),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_on = 1'b0;

  // ---------------- behavioural model ----------------
  logic [1:0] m_wave_t [8];
  logic [5:0] m_freq_t [8];
  int         m_dur_t  [8];
  int         m_phase;   // 0 idle, 1 playing, 2 finishing
  int         m_step;
  int         m_rem;     // cycles left in the current step
  logic [1:0] m_wave;
  logic [5:0] m_freq;

  task automatic m_load(input int i);
    m_phase = 1;
    m_step  = i;
    m_rem   = m_dur_t[i] * PRESC;
    m_wave  = m_wave_t[i];
    m_freq  = m_freq_t[i];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_wave_t[i] = '0; m_freq_t[i] = '0; m_dur_t[i] = 0;
      end
      m_phase = 0; m_step = 0; m_rem = 0; m_wave = '0; m_freq = '0;
    end else if (ena) begin
      case (m_phase)
        0: begin
          if (start && !stop) begin
            if (m_dur_t[0] != 0) m_load(0);
            else m_phase = 2;
          end
          if (wr_en) begin
            m_dur_t[wr_addr]  = int'(wr_data[7:0]);
            m_freq_t[wr_addr] = wr_data[13:8];
            m_wave_t[wr_addr] = wr_data[15:14];
          end
        end
        1: begin
          if (stop) begin
            m_phase = 2;
          end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
              if (m_step + 1 < 8 && m_dur_t[m_step + 1] != 0) m_load(m_step + 1);
              else if (loop_en && m_dur_t[0] != 0) m_load(0);
              else m_phase = 2;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      n_vec++;
      if (wave_sel !== m_wave || freq_code !== m_freq || step_idx !== 3'(m_step) ||
          gen_en !== (m_phase == 1) || busy !== (m_phase == 1) || done !== (m_phase == 2)) begin
        n_miss++;
        $display("FAIL model_cmp t=%0t got wave=%0d freq=%0d idx=%0d gen=%0b busy=%0b done=%0b exp wave=%0d freq=%0d idx=%0d gen=%0b busy=%0b done=%0b",
                 $time, wave_sel, freq_code, step_idx, gen_en, busy, done,
                 m_wave, m_freq, m_step, m_phase == 1, m_phase == 1, m_phase == 2);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] w, input int f, input int d);
    return {w, 6'(f), 8'(d)};
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Leaves the caller at the negedge right after start was sampled
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int c_a, c_b, c_c, c_done, done_at;
  bit found;

  initial begin
    rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    chk("rst_gen", int'(gen_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(step_idx), 0);

    // 1: two-step sequence, no loop
    wr(0, mk(WAVE_SQUARE, 5, 2));
    wr(1, mk(WAVE_SAW, 9, 1));
    wr(2, mk(WAVE_SINE, 0, 0));
    pulse_start();
    c_a = 0; c_b = 0; c_done = 0; done_at = -1;
    for (int k = 0; k < 20; k++) begin
      if (gen_en && wave_sel == 2'd1 && freq_code == 6'd5) c_a++;
      if (gen_en && wave_sel == 2'd3 && freq_code == 6'd9) c_b++;
      if (done) begin c_done++; done_at = k; end
      @(negedge clk);
    end
    chk("t1_square_cycles", c_a, 8);
    chk("t1_saw_cycles", c_b, 4);
    chk("t1_done_count", c_done, 1);
    chk("t1_done_at", done_at, 12);
    chk("t1_gen_after", int'(gen_en), 0);

    // 2: looping, then stop during e1
    loop_en = 1'b1;
    pulse_start();
    c_a = 0;
    for (int k = 0; k < 32; k++) begin
      if (!gen_en) c_a++;
      if (k == 8 || k == 20) chk("t2_idx_e1", int'(step_idx), 1);
      if (k == 12 || k == 24) chk("t2_idx_e0", int'(step_idx), 0);
      @(negedge clk);
    end
    chk("t2_gap_cycles", c_a, 0);
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      if (gen_en && step_idx == 3'd1) found = 1'b1;
      else @(negedge clk);
    end
    chk("t2_reach_e1", int'(found), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t2_done_after_stop", int'(done), 1);
    c_done = 0;
    for (int k = 0; k < 5; k++) begin
      if (done) c_done++;
      @(negedge clk);
    end
    chk("t2_single_done", c_done, 1);
    loop_en = 1'b0;

    // 3: empty first entry, then start+stop together
    wr(0, mk(WAVE_SINE, 7, 0));
    pulse_start();
    c_a = 0; done_at = -1;
    for (int k = 0; k < 6; k++) begin
      if (busy) c_a++;
      if (done && done_at < 0) done_at = k;
      @(negedge clk);
    end
    chk("t3_busy_cycles", c_a, 0);
    chk("t3_done_at", done_at, 0);
    wr(0, mk(WAVE_SQUARE, 5, 2));
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    c_a = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy || done) c_a++;
      @(negedge clk);
    end
    chk("t3_start_stop_noop", c_a, 0);

    // 4: full table, every step one tick
    for (int i = 0; i < 8; i++) wr(i, mk(2'(i % 4), 10 + i, 1));
    pulse_start();
    c_a = 0; done_at = -1;
    for (int k = 0; k < 36; k++) begin
      if (k < 32 && gen_en && int'(step_idx) == k / 4) c_a++;
      if (done) done_at = k;
      @(negedge clk);
    end
    chk("t4_idx_walk", c_a, 32);
    chk("t4_done_at", done_at, 32);

    // 5: write during RUN dropped, ena low stretches the step
    wr(0, mk(WAVE_SQUARE, 5, 2));
    wr(1, mk(WAVE_SAW, 9, 1));
    wr(2, mk(WAVE_SINE, 0, 0));
    pulse_start();
    c_a = 0; c_b = 0; c_c = 0; c_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 3) begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = mk(WAVE_TRI, 20, 3); end
      if (k == 4) begin wr_en = 1'b0; ena = 1'b0; end
      if (k == 14) ena = 1'b1;
      if (gen_en && step_idx == 3'd0) c_a++;
      if (gen_en && step_idx == 3'd1 && wave_sel == 2'd3 && freq_code == 6'd9) c_b++;
      if (gen_en && wave_sel == 2'd2) c_c++;
      if (done) c_done++;
      @(negedge clk);
    end
    chk("t5_step0_len", c_a, 18);
    chk("t5_old_e1_cycles", c_b, 4);
    chk("t5_new_e1_cycles", c_c, 0);
    chk("t5_done_count", c_done, 1);

    // 6: async reset mid-RUN
    loop_en = 1'b1;
    pulse_start();
    repeat (5) @(negedge clk);
    chk("t6_running", int'(gen_en), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_gen", int'(gen_en), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_wave", int'(wave_sel), 0);
    chk("t6_rst_freq", int'(freq_code), 0);
    chk("t6_rst_idx", int'(step_idx), 0);
    chk("t6_rst_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    loop_en = 1'b0;
    pulse_start();
    chk("t6_cleared_busy", int'(busy), 0);
    chk("t6_cleared_done", int'(done), 1);
    repeat (3) @(negedge clk);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
